pump_ctrl_input_unit: RTL and testbench
=======================================

Name: pump_ctrl_input_unit

Overview:
- Front-end timing and operator-input block for the water-level/pump controller.
- Produces a one-cycle 1 Hz tick that paces water-level updates.
- Debounces the water-level key (btn0) into a clean level and a one-cycle press pulse.
- Debounces the speed key (btn7) and holds the selected pump speed (slow/medium/fast), which the level controller subtracts each tick.

Parameters:
- CLK_DIV, 100_000_000: clk cycles per tick period (100 MHz gives 1 Hz); must be ≥ 2.
- DEBOUNCE_CYCLES, 2_000_000: cycles a synchronized key must differ from its stable state before the change is accepted (20 ms at 100 MHz); must be ≥ 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn0  input  1  raw water-level key, active-high, asynchronous to clk, bouncy.
- btn7  input  1  raw pump-speed key, active-high, asynchronous to clk, bouncy.
- tick_1hz  output  1  one-cycle pulse every CLK_DIV cycles.
- btn0_level  output  1  debounced level of btn0.
- btn0_press  output  1  one-cycle pulse on accepted btn0 0→1 transition.
- pump_speed  output  2  current pump speed: 1=slow, 2=medium, 3=fast; never 0.

Behaviour:
- Reset (rst=0), applied asynchronously and immediately:
  - tick counter=0, tick_1hz=0
  - synchronizers and debounce counters cleared, stable states=0
  - btn0_level=0, btn0_press=0
  - pump_speed=1
- Release of reset is sampled on the next rising clk edge.
- Tick generator:
  - Counter runs 0..CLK_DIV-1 and wraps to 0.
  - tick_1hz is registered and is 1 for exactly the cycle after the counter reaches CLK_DIV-1.
  - First pulse is CLK_DIV edges after reset release; then exactly one pulse per CLK_DIV cycles, free-running, never two consecutive high cycles.
- Debouncer (identical instance for btn0 and btn7):
  - Each raw key passes through a 2-flop synchronizer.
  - Counter increments each cycle the synchronized value differs from the stable state.
  - Counter clears to 0 on any cycle they match, so a glitch shorter than DEBOUNCE_CYCLES is fully discarded.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable state takes the new value on the next edge and the counter clears.
  - The press pulse is registered and asserted for exactly that one cycle, only for 0→1 transitions.
  - Latency from a clean raw edge to the stable change and pulse: 2+DEBOUNCE_CYCLES rising edges.
  - Holding the key gives one pulse only. Release updates the level after the same latency with no pulse.
- btn0_level and btn0_press come from the btn0 debouncer.
- Speed selector:
  - Driven by the btn7 debouncer's internal press pulse, which is not a port.
  - On each pulse, pump_speed advances 1→2→3→1 on the next edge, so it updates 1 cycle after the pulse.
  - Holds otherwise. Value 0 is unreachable; if ever present it recovers to 1 on the next pulse.
- btn0 and btn7 paths are fully independent: simultaneous presses each produce their own result in the same cycles. The tick is unaffected by key activity.
- Reset asserted mid-debounce or mid-count aborts all progress; no pulse is emitted after release until a fresh full debounce interval.
- All outputs are driven directly from flops (glitch-free).

Test Plan (run with CLK_DIV=10, DEBOUNCE_CYCLES=4):
- Tick: release reset, hold keys low for 40 cycles → tick_1hz high exactly at edges 10, 20, 30, 40 after release, each for 1 cycle; pump_speed=1, btn0_level=0 throughout.
- Clean press: raise btn0 and hold 20 cycles → btn0_press single 1-cycle pulse at edge 6 after the change, with btn0_level=1 from the same edge. Lower btn0 → btn0_level=0 at edge 6, no pulse.
- Bounce reject: toggle btn0 high for 3 cycles, low 1, high 2, low → btn0_level stays 0 and btn0_press never asserts. Then a 6-cycle high → exactly one pulse.
- Speed cycling: four clean btn7 presses (each held 10 cycles, gap 10) → pump_speed sequence 1→2→3→1→2, each change 1 cycle after the internal press (edge 7 after the raw rise).
- Simultaneous keys: raise btn0 and btn7 on the same cycle → btn0_press at edge 6 and pump_speed 1→2 at edge 7. The tick period is unchanged.
- Reset mid-operation: press btn7 twice (speed=3), raise btn0, assert rst after 3 cycles for 2 cycles, keep btn0 high → immediately pump_speed=1, btn0_level=0, tick_1hz=0. After release, btn0_press at edge 6 and the first tick at edge 10.

Source files
------------

// File: rtl/pump_ctrl_input_unit_if.sv
// Operator-key and timing signals between the pump controller input unit and its user.
// The unit itself connects through the slave modport.
interface pump_ctrl_input_unit_if;
  logic       btn0;
  logic       btn7;
  logic       tick_1hz;
  logic       btn0_level;
  logic       btn0_press;
  logic [1:0] pump_speed;

  modport master (
    output btn0,
    output btn7,
    input  tick_1hz,
    input  btn0_level,
    input  btn0_press,
    input  pump_speed
  );

  modport slave (
    input  btn0,
    input  btn7,
    output tick_1hz,
    output btn0_level,
    output btn0_press,
    output pump_speed
  );
endinterface

// File: rtl/pump_ctrl_input_unit.sv
// Pump controller front end: 1 Hz tick, btn0 level/press debouncing and the btn7 speed selector.
// Both keys share one debouncer datapath, indexed 0 = btn0 and 1 = btn7.
module pump_ctrl_input_unit #(
  parameter int unsigned CLK_DIV         = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input logic                  clk,
  input logic                  rst,
  pump_ctrl_input_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0]         tick_cnt_q, tick_cnt_d;
  logic                    tick_q, tick_d;
  logic [1:0]              raw;
  logic [1:0]              sync1_q, sync1_d;
  logic [1:0]              sync2_q, sync2_d;
  logic [1:0]              stable_q, stable_d;
  logic [1:0]              press_q, press_d;
  logic [1:0][DbW-1:0]     db_cnt_q, db_cnt_d;
  logic [1:0]              speed_q, speed_d;

  assign raw = {bus.btn7, bus.btn0};

  always_comb begin
    tick_d     = (tick_cnt_q == CntMax);
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + CntW'(1);
  end

  // Any cycle where the synchronized key matches the stable state discards progress.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = 2'b00;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          stable_d[i] = sync2_q[i];
          press_d[i]  = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // 3 and the unreachable 0 both fall back to slow.
  always_comb begin
    speed_d = speed_q;
    if (press_q[1]) begin
      case (speed_q)
        2'd1:    speed_d = 2'd2;
        2'd2:    speed_d = 2'd3;
        default: speed_d = 2'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      stable_q   <= 2'b00;
      press_q    <= 2'b00;
      db_cnt_q   <= '0;
      speed_q    <= 2'd1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      press_q    <= press_d;
      db_cnt_q   <= db_cnt_d;
      speed_q    <= speed_d;
    end
  end

  assign bus.tick_1hz   = tick_q;
  assign bus.btn0_level = stable_q[0];
  assign bus.btn0_press = press_q[0];
  assign bus.pump_speed = speed_q;

endmodule

// File: tb/tb_pump_ctrl_input_unit.sv
// Scoreboard bench for pump_ctrl_input_unit with CLK_DIV=10, DEBOUNCE_CYCLES=4.
// Expected output events are queued when keys are driven and retired when the DUT shows them.
module tb_pump_ctrl_input_unit;

  localparam int unsigned Div = 10;
  localparam int unsigned Deb = 4;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_total;
  int   n_bad;
  int   spd;
  int   level_prev;
  int   speed_prev;

  int   press_q[$];
  ev_t  level_q[$];
  ev_t  speed_q[$];

  pump_ctrl_input_unit_if bus ();

  pump_ctrl_input_unit #(
    .CLK_DIV        (Div),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the most recent reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check_eq("tick", int'(bus.tick_1hz), int'(cyc != 0 && (cyc % Div) == 0));
      if (bus.btn0_press) begin
        if (press_q.size() == 0) check_eq("press_unexpected", 1, 0);
        else check_eq("press_cycle", cyc, press_q.pop_front());
      end
      if (int'(bus.btn0_level) != level_prev) begin
        if (level_q.size() == 0) begin
          check_eq("level_unexpected", int'(bus.btn0_level), level_prev);
        end else begin
          ev_t e;
          e = level_q.pop_front();
          check_eq("level_cycle", cyc, e.cyc);
          check_eq("level_value", int'(bus.btn0_level), e.val);
        end
      end
      if (int'(bus.pump_speed) != speed_prev) begin
        if (speed_q.size() == 0) begin
          check_eq("speed_unexpected", int'(bus.pump_speed), speed_prev);
        end else begin
          ev_t e;
          e = speed_q.pop_front();
          check_eq("speed_cycle", cyc, e.cyc);
          check_eq("speed_value", int'(bus.pump_speed), e.val);
        end
      end
    end
    level_prev = int'(bus.btn0_level);
    speed_prev = int'(bus.pump_speed);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic btn0_set(input logic v, input bit pulse);
    bus.btn0 = v;
    level_q.push_back('{cyc + 2 + Deb, int'(v)});
    if (pulse) press_q.push_back(cyc + 2 + Deb);
  endtask

  task automatic btn7_press();
    bus.btn7 = 1'b1;
    spd = (spd == 3) ? 1 : spd + 1;
    speed_q.push_back('{cyc + 3 + Deb, spd});
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    spd        = 1;
    level_prev = 0;
    speed_prev = 1;
    rst        = 1'b0;
    bus.btn0   = 1'b0;
    bus.btn7   = 1'b0;
    step(3);
    check_eq("rst_tick", int'(bus.tick_1hz), 0);
    check_eq("rst_level", int'(bus.btn0_level), 0);
    check_eq("rst_press", int'(bus.btn0_press), 0);
    check_eq("rst_speed", int'(bus.pump_speed), 1);
    rst = 1'b1;

    // Idle: only the tick model is exercised.
    step(40);

    // Clean press and release.
    btn0_set(1'b1, 1'b1);
    step(20);
    btn0_set(1'b0, 1'b0);
    step(20);

    // Bounces shorter than the debounce window are discarded.
    bus.btn0 = 1'b1; step(3);
    bus.btn0 = 1'b0; step(1);
    bus.btn0 = 1'b1; step(2);
    bus.btn0 = 1'b0; step(10);
    btn0_set(1'b1, 1'b1);
    step(6);
    btn0_set(1'b0, 1'b0);
    step(12);

    // Speed cycling.
    for (int k = 0; k < 4; k++) begin
      btn7_press();
      step(10);
      bus.btn7 = 1'b0;
      step(10);
    end

    // Both keys on the same cycle.
    btn0_set(1'b1, 1'b1);
    btn7_press();
    step(12);
    btn0_set(1'b0, 1'b0);
    bus.btn7 = 1'b0;
    step(12);

    // Reset in the middle of a debounce interval.
    for (int k = 0; k < 2; k++) begin
      btn7_press();
      step(10);
      bus.btn7 = 1'b0;
      step(10);
    end
    check_eq("pre_rst_speed", int'(bus.pump_speed), spd);
    bus.btn0 = 1'b1;
    step(3);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_speed", int'(bus.pump_speed), 1);
    check_eq("mid_rst_level", int'(bus.btn0_level), 0);
    check_eq("mid_rst_tick", int'(bus.tick_1hz), 0);
    check_eq("mid_rst_press", int'(bus.btn0_press), 0);
    spd = 1;
    step(2);
    rst = 1'b1;
    // Synchronizers were cleared, so the still-held key needs a full interval from release.
    level_q.push_back('{2 + Deb, 1});
    press_q.push_back(2 + Deb);
    step(20);
    btn0_set(1'b0, 1'b0);
    step(12);

    check_eq("press_pending", press_q.size(), 0);
    check_eq("level_pending", level_q.size(), 0);
    check_eq("speed_pending", speed_q.size(), 0);
    check_eq("final_speed", int'(bus.pump_speed), spd);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
